// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline hazard scoreboard
package pipe_pkg;

    // Forward select value meaning "use the register-file read data"
    localparam int FWD_RF = 0;

    // Scoreboard destination field width; must be >= the register address width in use
    localparam int SB_DST_W = 8;

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                is_load;
    } sb_entry_t;

    // Width of a forward select: regfile plus one code per tracked stage
    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hz_operand_match.sv
// rtl/hz_operand_match.sv - youngest-first scoreboard match and forward mux for one operand
module hz_operand_match
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = 2
) (
    input  logic [DEPTH-1:0]          sb_valid,
    input  logic [DEPTH-1:0]          sb_is_load,
    input  logic [DEPTH*SB_DST_W-1:0] sb_dst,
    input  logic [REG_AW-1:0]         src,
    input  logic                      src_used,
    input  logic [DEPTH*DATA_W-1:0]   stage_result,
    input  logic [DATA_W-1:0]         rf_data,
    output logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         data,
    output logic                      load_use
);

    logic hit;

    // First (youngest) valid producer of src wins; a load too young to forward raises load_use
    always_comb begin
        sel      = SEL_W'(FWD_RF);
        data     = rf_data;
        load_use = 1'b0;
        hit      = 1'b0;
        if (src == '0) begin
            data = '0;
        end else if (src_used) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit && sb_valid[k] && (sb_dst[k*SB_DST_W +: SB_DST_W] == SB_DST_W'(src))) begin
                    hit = 1'b1;
                    if (sb_is_load[k] && (k < LOAD_STAGE)) begin
                        load_use = 1'b1;
                    end else begin
                        sel  = SEL_W'(k + 1);
                        data = stage_result[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - shifting write scoreboard with stall, flush and forwarding control
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int BR_STAGE   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [REG_AW-1:0]          id_rs,
    input  logic [REG_AW-1:0]          id_rt,
    input  logic                       id_use_rs,
    input  logic                       id_use_rt,
    input  logic [REG_AW-1:0]          id_dst,
    input  logic                       id_reg_write,
    input  logic                       id_is_load,
    input  logic                       id_jump,
    input  logic                       br_taken,
    input  logic [DATA_W-1:0]          rf_rs_data,
    input  logic [DATA_W-1:0]          rf_rt_data,
    input  logic [DEPTH*DATA_W-1:0]    stage_result,
    output logic                       stall_if,
    output logic                       stall_id,
    output logic                       bubble_ex,
    output logic                       flush_if_id,
    output logic [fwd_sel_w(DEPTH)-1:0] fwd_rs_sel,
    output logic [fwd_sel_w(DEPTH)-1:0] fwd_rt_sel,
    output logic [DATA_W-1:0]          fwd_rs_data,
    output logic [DATA_W-1:0]          fwd_rt_data,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int SEL_W = fwd_sel_w(DEPTH);

    sb_entry_t sb      [DEPTH];
    sb_entry_t sb_next [DEPTH];
    sb_entry_t id_entry;

    logic [DEPTH-1:0]          sb_valid;
    logic [DEPTH-1:0]          sb_is_load;
    logic [DEPTH*SB_DST_W-1:0] sb_dst;

    logic rs_load_use;
    logic rt_load_use;
    logic hazard;
    logic stall;
    logic issue;
    logic flush_evt;

    assign id_entry = '{valid: 1'b1, dst: SB_DST_W'(id_dst), is_load: id_is_load};

    // Flatten the scoreboard for the per-operand matchers
    always_comb begin
        sb_valid   = '0;
        sb_is_load = '0;
        sb_dst     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sb_valid[k]                        = sb[k].valid;
            sb_is_load[k]                      = sb[k].is_load;
            sb_dst[k*SB_DST_W +: SB_DST_W]     = sb[k].dst;
        end
    end

    hz_operand_match #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
    ) u_match_rs (
        .sb_valid     (sb_valid),
        .sb_is_load   (sb_is_load),
        .sb_dst       (sb_dst),
        .src          (id_rs),
        .src_used     (id_use_rs),
        .stage_result (stage_result),
        .rf_data      (rf_rs_data),
        .sel          (fwd_rs_sel),
        .data         (fwd_rs_data),
        .load_use     (rs_load_use)
    );

    hz_operand_match #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
    ) u_match_rt (
        .sb_valid     (sb_valid),
        .sb_is_load   (sb_is_load),
        .sb_dst       (sb_dst),
        .src          (id_rt),
        .src_used     (id_use_rt),
        .stage_result (stage_result),
        .rf_data      (rf_rt_data),
        .sel          (fwd_rt_sel),
        .data         (fwd_rt_data),
        .load_use     (rt_load_use)
    );

    // A taken branch overrides a load-use stall; control outputs are forced low while in reset
    always_comb begin
        hazard      = id_valid & (rs_load_use | rt_load_use);
        stall       = reset & hazard & ~br_taken;
        issue       = id_valid & id_reg_write & ~hazard & ~br_taken;
        flush_evt   = reset & (br_taken | id_jump);
        stall_if    = stall;
        stall_id    = stall;
        bubble_ex   = stall | (reset & br_taken);
        flush_if_id = flush_evt;
    end

    // Next scoreboard: drop wrong-path entries younger than the branch, then age everything by one stage
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sb_next[k] = '0;
        end
        sb_next[0] = issue ? id_entry : '0;
        for (int k = 1; k < DEPTH; k++) begin
            sb_next[k] = sb[k-1];
            if (br_taken && ((k - 1) < BR_STAGE)) begin
                sb_next[k].valid = 1'b0;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                sb[k] <= sb_next[k];
            end
        end
    end

    // Saturating stall event counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Saturating flush event counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
        end else if (flush_evt && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
